// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-port arbiter sharing one single-ported SPRAM
// Grants one transaction at a time: IDLE -> ISSUE -> CAPTURE -> RESP, done at T+3.
module spram_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_wen,
  input  logic        m0_ren,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_wen,
  input  logic        m1_ren,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        m0_done_q, m0_done_d;
  logic        m1_done_q, m1_done_d;

  logic req0;
  logic req1;
  logic pick1;

  assign req0 = m0_ren | m0_wen;
  assign req1 = m1_ren | m1_wen;
  // Port 1 wins when alone, or on a tie when round-robin says port 0 went last.
  assign pick1 = req1 & (~req0 | (~FIXED_PRIORITY & ~last_grant_q));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    m0_done_d    = 1'b0;
    m1_done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          gnt_d        = pick1;
          last_grant_d = pick1;
          addr_d       = pick1 ? m1_addr  : m0_addr;
          wdata_d      = pick1 ? m1_wdata : m0_wdata;
          wmask_d      = pick1 ? m1_wmask : m0_wmask;
          write_d      = pick1 ? m1_wen   : m0_wen;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (gnt_q) begin
          m1_done_d = 1'b1;
          if (!write_q) m1_rdata_d = mem_rdata;
        end else begin
          m0_done_d = 1'b1;
          if (!write_q) m0_rdata_d = mem_rdata;
        end
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wmask_q      <= 4'd0;
      m0_rdata_q   <= 32'd0;
      m1_rdata_q   <= 32'd0;
      m0_done_q    <= 1'b0;
      m1_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_done_q    <= m0_done_d;
      m1_done_q    <= m1_done_d;
    end
  end

  // Address stays on the latch through CAPTURE/RESP for the SPRAM bank-select read mux.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign mem_wen   = (state_q == S_ISSUE) &  write_q;
  assign mem_ren   = (state_q == S_ISSUE) & ~write_q;

  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_done  = m0_done_q;
  assign m1_done  = m1_done_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - self-checking bench for spram_arbiter
// Instance 0 is round-robin, instance 1 fixed-priority; each has its own SPRAM model.
module tb_spram_arbiter;

  logic        clk;
  logic        rst;
  logic        mem_init;

  logic [31:0] a_addr  [2][2];
  logic [31:0] a_wdata [2][2];
  logic [3:0]  a_wmask [2][2];
  logic        a_wen   [2][2];
  logic        a_ren   [2][2];
  logic [31:0] o_rdata [2][2];
  logic        o_done  [2][2];

  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wmask [2];
  logic        mem_wen   [2];
  logic        mem_ren   [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] phys    [2][64];
  logic [31:0] ref_mem [2][64];

  int n_vec;
  int n_err;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spram_arbiter #(.FIXED_PRIORITY(g != 0)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0_addr   (a_addr[g][0]),
      .m0_wdata  (a_wdata[g][0]),
      .m0_wmask  (a_wmask[g][0]),
      .m0_wen    (a_wen[g][0]),
      .m0_ren    (a_ren[g][0]),
      .m0_rdata  (o_rdata[g][0]),
      .m0_done   (o_done[g][0]),
      .m1_addr   (a_addr[g][1]),
      .m1_wdata  (a_wdata[g][1]),
      .m1_wmask  (a_wmask[g][1]),
      .m1_wen    (a_wen[g][1]),
      .m1_ren    (a_ren[g][1]),
      .m1_rdata  (o_rdata[g][1]),
      .m1_done   (o_done[g][1]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_wmask (mem_wmask[g]),
      .mem_wen   (mem_wen[g]),
      .mem_ren   (mem_ren[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small word store: bit 16 picks the bank, bits 6:2 the word.
  function automatic int slot(input logic [31:0] a);
    return int'({a[16], a[6:2]});
  endfunction

  function automatic logic [31:0] init_val(input int i);
    case (i)
      4:       return 32'hDEAD_BEEF;
      8:       return 32'hAABB_CCDD;
      31:      return 32'h1111_FFFC;
      32:      return 32'h5A5A_0001;
      default: return 32'h5EED_0000 | 32'(i);
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] wm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_init) begin
        for (int i = 0; i < 64; i++) phys[d][i] <= init_val(i);
      end else if (mem_wen[d]) begin
        phys[d][slot(mem_addr[d])] <= merge(phys[d][slot(mem_addr[d])], mem_wdata[d], mem_wmask[d]);
      end
      if (mem_ren[d]) mem_rdata[d] <= phys[d][slot(mem_addr[d])];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int d, input int p, input logic wen, input logic ren,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wmask);
    a_wen[d][p]   = wen;
    a_ren[d][p]   = ren;
    a_addr[d][p]  = addr;
    a_wdata[d][p] = wdata;
    a_wmask[d][p] = wmask;
  endtask

  task automatic clear_all();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) set_req(d, p, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  typedef struct {
    logic        port;
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [10];

  // Random-phase reference state, one in-flight transaction per instance.
  logic        m_last  [2];
  logic        m_inf   [2];
  int          m_gcyc  [2];
  logic        m_gport [2];
  logic        m_gwr   [2];
  logic [31:0] m_gaddr [2];
  logic [31:0] m_gdata [2];
  logic [3:0]  m_gmask [2];
  logic [31:0] m_gval  [2];
  logic [31:0] m_rdata [2][2];
  logic        m_fin   [2][2];

  initial begin
    logic [1:0]  exp_done;
    logic        exp_w;
    logic        exp_r;
    logic        win;
    logic        r0;
    logic        r1;
    int          s;
    int          k;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    mem_init = 1'b1;
    clear_all();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) ref_mem[d][i] = init_val(i);

    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'hF000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'hF000_0020, 32'h1122_3344, 4'h5, 32'h0000_0000};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'hF000_0020, 32'h0000_0000, 4'h0, 32'hAA22_CC44};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'hF000_0010, 32'h0102_0304, 4'hF, 32'hAA22_CC44};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'hF000_0010, 32'h0000_0000, 4'h0, 32'h0102_0304};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'hF001_0000, 32'h0000_0000, 4'h0, 32'h5A5A_0001};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 32'hF000_FFFC, 32'h0000_0000, 4'h0, 32'h1111_FFFC};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'hF001_0000, 32'hFFFF_FFFF, 4'h0, 32'hAA22_CC44};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 32'hF001_0000, 32'h0000_0000, 4'h0, 32'h5A5A_0001};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 4'h0, 32'h5EED_0001};

    repeat (3) tick();
    mem_init = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("reset_done", {o_done[d][1], o_done[d][0]}, 2'b00);
      check("reset_rdata", {o_rdata[d][1], o_rdata[d][0]}, 64'd0);
      check("reset_strobe", {mem_wen[d], mem_ren[d]}, 2'b00);
      check("reset_latch", {mem_addr[d], mem_wdata[d][27:0], mem_wmask[d]}, 64'd0);
    end
    rst = 1'b0;

    // Single-port transactions on the round-robin instance.
    for (int r = 0; r < 10; r++) begin
      clear_all();
      set_req(0, int'(tbl[r].port), tbl[r].wen, tbl[r].ren, tbl[r].addr, tbl[r].wdata, tbl[r].wmask);
      tick();
      check("tbl_issue_strobe", {mem_wen[0], mem_ren[0]}, {tbl[r].wen, tbl[r].ren & ~tbl[r].wen});
      check("tbl_issue_addr", mem_addr[0], tbl[r].addr);
      if (tbl[r].wen) check("tbl_issue_wdata", {mem_wdata[0], mem_wmask[0]}, {tbl[r].wdata, tbl[r].wmask});
      check("tbl_issue_done", {o_done[0][1], o_done[0][0]}, 2'b00);
      tick();
      check("tbl_capture_strobe", {mem_wen[0], mem_ren[0]}, 2'b00);
      check("tbl_capture_done", {o_done[0][1], o_done[0][0]}, 2'b00);
      tick();
      check("tbl_resp_done", {o_done[0][1], o_done[0][0]}, tbl[r].port ? 2'b10 : 2'b01);
      check("tbl_resp_rdata", o_rdata[0][tbl[r].port], tbl[r].exp_rdata);
      check("tbl_resp_addr", mem_addr[0], tbl[r].addr);
      tick();
    end
    clear_all();

    // Both ports saturated with reads on both instances.
    for (int d = 0; d < 2; d++) begin
      set_req(d, 0, 1'b0, 1'b1, 32'hF000_0010, 32'd0, 4'd0);
      set_req(d, 1, 1'b0, 1'b1, 32'hF000_0020, 32'd0, 4'd0);
    end
    for (int c = 1; c <= 32; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        if ((c % 4) != 3) exp_done = 2'b00;
        else if (d == 1) exp_done = 2'b01;
        else exp_done = ((c / 4) % 2 == 1) ? 2'b10 : 2'b01;
        check(d == 0 ? "sat_rr_done" : "sat_fp_done", {o_done[d][1], o_done[d][0]}, exp_done);
      end
    end
    clear_all();
    check("sat_rr_rdata", {o_rdata[0][1], o_rdata[0][0]}, {32'hAA22_CC44, 32'h0102_0304});
    check("sat_fp_rdata", {o_rdata[1][1], o_rdata[1][0]}, {32'h0000_0000, 32'hDEAD_BEEF});

    // Request fields altered while the transaction is in flight.
    set_req(0, 0, 1'b0, 1'b1, 32'hF001_0000, 32'd0, 4'd0);
    tick();
    check("chg_issue_addr", mem_addr[0], 32'hF001_0000);
    a_addr[0][0] = 32'hF000_0010;
    tick();
    check("chg_capture_addr", mem_addr[0], 32'hF001_0000);
    a_addr[0][0] = 32'h0000_0000;
    a_wen[0][0] = 1'b1;
    tick();
    check("chg_resp_addr", mem_addr[0], 32'hF001_0000);
    check("chg_resp_done", {o_done[0][1], o_done[0][0]}, 2'b01);
    check("chg_resp_rdata", o_rdata[0][0], 32'h5A5A_0001);
    tick();
    clear_all();

    // Reset pulsed during CAPTURE of a port 0 read; request held throughout.
    set_req(0, 0, 1'b0, 1'b1, 32'hF000_0020, 32'd0, 4'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rstmid_done", {o_done[0][1], o_done[0][0]}, 2'b00);
    check("rstmid_rdata", {o_rdata[0][1], o_rdata[0][0]}, 64'd0);
    check("rstmid_strobe", {mem_wen[0], mem_ren[0]}, 2'b00);
    tick();
    rst = 1'b0;
    tick();
    check("rstmid_reissue", {mem_wen[0], mem_ren[0], o_done[0][1], o_done[0][0]}, 4'b0100);
    tick();
    check("rstmid_capture", {o_done[0][1], o_done[0][0]}, 2'b00);
    tick();
    check("rstmid_done_after", {o_done[0][1], o_done[0][0]}, 2'b01);
    check("rstmid_rdata_after", o_rdata[0][0], 32'hAA22_CC44);
    tick();
    clear_all();

    // Randomized traffic against a transaction-level reference.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 1'b1;
      m_inf[d]  = 1'b0;
      m_gcyc[d] = 0;
      for (int p = 0; p < 2; p++) begin
        m_rdata[d][p] = 32'd0;
        m_fin[d][p]   = 1'b0;
      end
    end
    for (int n = 0; n < 800; n++) begin
      if (n > 0) tick();
      for (int d = 0; d < 2; d++) begin
        exp_done = 2'b00;
        exp_w = 1'b0;
        exp_r = 1'b0;
        if (m_inf[d] && n == m_gcyc[d] + 1) begin
          exp_w = m_gwr[d];
          exp_r = ~m_gwr[d];
          check("rnd_addr", mem_addr[d], m_gaddr[d]);
        end
        if (m_inf[d] && n == m_gcyc[d] + 3) begin
          exp_done[m_gport[d]] = 1'b1;
          m_fin[d][m_gport[d]] = 1'b1;
          if (!m_gwr[d]) m_rdata[d][m_gport[d]] = m_gval[d];
        end
        check("rnd_done", {o_done[d][1], o_done[d][0]}, exp_done);
        check("rnd_strobe", {mem_wen[d], mem_ren[d]}, {exp_w, exp_r});
        check("rnd_rdata", {o_rdata[d][1], o_rdata[d][0]}, {m_rdata[d][1], m_rdata[d][0]});

        for (int p = 0; p < 2; p++) begin
          if (m_fin[d][p] && !exp_done[p]) begin
            m_fin[d][p] = 1'b0;
            set_req(d, p, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
          end
          if (!(a_wen[d][p] | a_ren[d][p]) && $urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, 2);
            set_req(d, p, k != 0, k != 1,
                    ($urandom_range(0, 8) == 8) ? 32'hFFFF_FFFC : (32'h2000_0040 + 32'($urandom_range(0, 7)) * 4),
                    $urandom, 4'($urandom_range(0, 15)));
          end
        end

        if (!m_inf[d] || n >= m_gcyc[d] + 4) begin
          m_inf[d] = 1'b0;
          r0 = a_wen[d][0] | a_ren[d][0];
          r1 = a_wen[d][1] | a_ren[d][1];
          if (r0 | r1) begin
            if (r0 && r1) win = (d == 1) ? 1'b0 : ~m_last[d];
            else win = r1;
            m_inf[d]   = 1'b1;
            m_gcyc[d]  = n;
            m_gport[d] = win;
            m_gwr[d]   = a_wen[d][win];
            m_gaddr[d] = a_addr[d][win];
            m_gdata[d] = a_wdata[d][win];
            m_gmask[d] = a_wmask[d][win];
            m_last[d]  = win;
            s = slot(m_gaddr[d]);
            if (m_gwr[d]) ref_mem[d][s] = merge(ref_mem[d][s], m_gdata[d], m_gmask[d]);
            else m_gval[d] = ref_mem[d][s];
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-port arbiter that shares one single-ported SPRAM instance between an instruction-fetch requester (port 0) and a load/store requester (port 1).
- Sits between the CPU bus masters and the SPRAM wrapper.
- Grants one transaction at a time, sequences the memory's one-cycle registered read, and returns a registered read word plus a one-cycle done pulse to the granted requester.
- Arbitration is round-robin, or fixed-priority by parameter.

Parameters:
FIXED_PRIORITY, 0, 1 = port 0 always wins ties; 0 = round-robin on ties.

Ports:
clk  input  1  system clock; all state on posedge
rst  input  1  asynchronous active-high reset
m0_addr  input  32  port 0 byte address
m0_wdata  input  32  port 0 write data
m0_wmask  input  4  port 0 byte write mask
m0_wen  input  1  port 0 write request (level, held until m0_done)
m0_ren  input  1  port 0 read request (level, held until m0_done)
m0_rdata  output  32  port 0 read data, registered
m0_done  output  1  port 0 completion pulse
m1_addr, m1_wdata, m1_wmask, m1_wen, m1_ren  input  32/32/4/1/1  port 1, same meaning as port 0
m1_rdata  output  32  port 1 read data, registered
m1_done  output  1  port 1 completion pulse
mem_addr  output  32  address to SPRAM
mem_wdata  output  32  write data to SPRAM
mem_wmask  output  4  byte mask to SPRAM
mem_wen  output  1  SPRAM write strobe
mem_ren  output  1  SPRAM read strobe
mem_rdata  input  32  SPRAM read data, valid the cycle after mem_ren

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=1.
  - m0_done=m1_done=0, m0_rdata=m1_rdata=0.
  - mem_wen=mem_ren=0, mem_addr/mem_wdata/mem_wmask latches=0.
- A port requests when (mN_ren | mN_wen). If both wen and ren are set, the operation is a write.
- State machine, one transaction per pass:
  - IDLE:
    - No request: stay.
    - One port requesting: grant it.
    - Both requesting: grant the port != last_grant. When FIXED_PRIORITY=1, grant port 0.
    - On grant: latch addr/wdata/wmask/op and grant id; set last_grant; go to ISSUE.
  - ISSUE: drive mem_* from the latches; exactly one of mem_wen/mem_ren=1 for this single cycle. Go to CAPTURE.
  - CAPTURE:
    - Strobes=0; mem_addr stays at the latched address, because the SPRAM bank-select read mux depends on it.
    - Read: mem_rdata is registered into the granted port's rdata.
    - Write: rdata is unchanged.
    - The granted port's done register is set; go to RESP.
  - RESP: mN_done=1 for exactly this cycle; mem_addr still held. Go to IDLE.
- Latency: request present in IDLE at cycle T gives done=1 at cycle T+3. Minimum spacing between grants is 4 cycles.
- mN_rdata holds its value until that port's next completed read.
- Requester protocol:
  - Hold request fields stable from assertion through the done cycle.
  - Drop or change them on the clock edge that ends the done cycle.
  - The arbiter samples requests only in IDLE. Inputs changing in ISSUE/CAPTURE/RESP have no effect on the in-flight transaction (the fields are latched).
- Ungranted port: done=0, rdata unchanged, waits indefinitely. With round-robin and both ports saturated, grants strictly alternate 0,1,0,1.
- mem_wen and mem_ren are never both 1, and are 0 outside ISSUE.
- m0_done and m1_done are never both 1.
- The arbiter does no address decoding; out-of-range addresses are passed through and still complete in 3 cycles.
- A write with wmask=0 still completes, with the mem_wen pulse issued.
- Reset asserted mid-transaction: immediate return to IDLE; no done is emitted. A write whose ISSUE cycle already occurred may have committed.

Test Plan:
- Reset, then m0_ren=1, m0_addr=F000_0010 (memory preloaded with 0xDEADBEEF): mem_ren pulses at cycle 1, m0_done at cycle 3 only, m0_rdata=DEADBEEF, m1_done=0 throughout.
- Port 1 write: m1_wen=1, addr F000_0020, wdata 11223344, wmask 0101; then read back via port 0: result is original bytes 3,1 with bytes 2,0 = 22,44; mem_wen high for exactly 1 cycle.
- Both ports continuously requesting reads for 8 transactions, round-robin: done order 0,1,0,1,..., each done 4 cycles apart. Repeat with FIXED_PRIORITY=1: port 1 never granted while port 0 requests.
- Request fields changed during ISSUE/CAPTURE (addr altered): the transaction completes on the latched address; mem_addr is constant from ISSUE through RESP. Bank-boundary address F001_0000: correct upper-bank data returned.
- rst pulsed during CAPTURE of a port 0 read: both dones 0, rdata=0, state IDLE; a held request re-issues and completes 3 cycles after rst falls.
- m0_wen=m0_ren=1 together: treated as a write (mem_wen=1, mem_ren=0), m0_rdata unchanged, done at T+3.
